neuron_accumulator: RTL and testbench

//  Downstream stage of the accelerator FSM / PE adder tree. Accumulates per-neuron partial sums
//  (one per 16-wide MAC pass), adds the neuron bias, then rescales, saturates and applies ReLU.

---
 rtl/neuron_accumulator.sv | 194 +++++++++++++++++++
 tb/tb_neuron_accumulator.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// Per-neuron partial-sum accumulator: bias add, rescale, saturate, optional ReLU,
// then one activation write per output neuron into the layer output BRAM.
module neuron_accumulator #(
    parameter int ACC_W     = 32,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     layer_start,
    input  logic [15:0]              num_neurons,
    input  logic [15:0]              out_base_addr,
    input  logic                     psum_valid,
    input  logic signed [ACC_W-1:0]  psum,
    input  logic                     psum_last,
    output logic                     psum_ready,
    output logic                     bias_rd_en,
    output logic [15:0]              bias_addr,
    input  logic signed [DATA_W-1:0] bias_data,
    output logic                     wr_en,
    output logic [15:0]              wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [15:0]              neuron_idx,
    output logic                     busy,
    output logic                     layer_done,
    output logic                     overflow_flag
);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        BIAS_RD,
        BIAS_ADD,
        ACT,
        WRITE
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ACT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] ACT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam int UP_W = ACC_W - DATA_W + 1;

    state_t state, state_nx;

    logic signed [ACC_W-1:0] acc;
    logic [15:0]             num_q;
    logic [15:0]             base_q;
    logic [15:0]             idx;
    logic                    zero_done;

    logic                    transfer;
    logic                    last_neuron;

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W:0]   add_a;
    logic signed [ACC_W:0]   add_b;
    logic signed [ACC_W:0]   add_sum;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] add_sat;

    logic signed [ACC_W-1:0] shr;
    logic [UP_W-1:0]         shr_up;
    logic                    act_ovf;
    logic [DATA_W-1:0]       act_sat;
    logic [DATA_W-1:0]       act_out;

    assign transfer    = psum_valid & psum_ready;
    assign last_neuron = (idx == num_q - 16'd1);

    // Bias is Q.FRAC_BITS; shift it up to the accumulator's Q.(2*FRAC_BITS).
    assign bias_ext = {{(ACC_W-DATA_W){bias_data[DATA_W-1]}}, bias_data}
                      <<< FRAC_BITS;

    always_comb begin
        add_a = {acc[ACC_W-1], acc};
        if (state == BIAS_ADD) begin
            add_b = {bias_ext[ACC_W-1], bias_ext};
        end else begin
            add_b = {psum[ACC_W-1], psum};
        end
        add_sum = add_a + add_b;
        add_ovf = add_sum[ACC_W] ^ add_sum[ACC_W-1];
        if (add_ovf) begin
            add_sat = add_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_sat = add_sum[ACC_W-1:0];
        end
    end

    always_comb begin
        shr     = acc >>> FRAC_BITS;
        shr_up  = shr[ACC_W-1:DATA_W-1];
        act_ovf = !((&shr_up) || !(|shr_up));
        if (act_ovf) begin
            act_sat = shr[ACC_W-1] ? ACT_MIN : ACT_MAX;
        end else begin
            act_sat = shr[DATA_W-1:0];
        end
        if (RELU_EN && act_sat[DATA_W-1]) begin
            act_out = '0;
        end else begin
            act_out = act_sat;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (layer_start && num_neurons != 16'd0) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (transfer && psum_last) begin
                    state_nx = BIAS_RD;
                end
            end
            BIAS_RD:  state_nx = BIAS_ADD;
            BIAS_ADD: state_nx = ACT;
            ACT:      state_nx = WRITE;
            WRITE:    state_nx = last_neuron ? IDLE : ACCUM;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            num_q         <= '0;
            base_q        <= '0;
            idx           <= '0;
            zero_done     <= 1'b0;
            overflow_flag <= 1'b0;
            wr_data       <= '0;
        end else begin
            zero_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (layer_start) begin
                        num_q         <= num_neurons;
                        base_q        <= out_base_addr;
                        acc           <= '0;
                        idx           <= '0;
                        overflow_flag <= 1'b0;
                        zero_done     <= (num_neurons == 16'd0);
                    end
                end
                ACCUM: begin
                    if (transfer) begin
                        acc <= add_sat;
                        if (add_ovf) overflow_flag <= 1'b1;
                    end
                end
                BIAS_ADD: begin
                    acc <= add_sat;
                    if (add_ovf) overflow_flag <= 1'b1;
                end
                ACT: begin
                    wr_data <= act_out;
                    if (act_ovf) overflow_flag <= 1'b1;
                end
                WRITE: begin
                    if (!last_neuron) begin
                        idx <= idx + 16'd1;
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign psum_ready = (state == ACCUM);
    assign bias_rd_en = (state == BIAS_RD);
    assign bias_addr  = idx;
    assign wr_en      = (state == WRITE);
    assign wr_addr    = base_q + idx;
    assign neuron_idx = idx;
    assign busy       = (state != IDLE);
    // An empty layer finishes one cycle after its start pulse.
    assign layer_done = ((state == WRITE) && last_neuron) || zero_done;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: a ReLU and a linear instance share
// one stimulus stream, each served by its own one-cycle-latency bias memory.
module tb_neuron_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        layer_start;
    logic [15:0] num_neurons;
    logic [15:0] out_base_addr;
    logic        psum_valid;
    logic [31:0] psum;
    logic        psum_last;

    logic        r_psum_ready, l_psum_ready;
    logic        r_bias_rd_en, l_bias_rd_en;
    logic [15:0] r_bias_addr, l_bias_addr;
    logic [15:0] r_bias_data, l_bias_data;
    logic        r_wr_en, l_wr_en;
    logic [15:0] r_wr_addr, l_wr_addr;
    logic [15:0] r_wr_data, l_wr_data;
    logic [15:0] r_neuron_idx, l_neuron_idx;
    logic        r_busy, l_busy;
    logic        r_layer_done, l_layer_done;
    logic        r_overflow_flag, l_overflow_flag;

    logic [15:0] bias_mem [0:7];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [15:0] last_addr = '0;
    logic [15:0] last_data = '0;
    logic [15:0] last_lin = '0;

    always #5 clk = ~clk;

    neuron_accumulator #(.RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst(rst), .layer_start(layer_start),
        .num_neurons(num_neurons), .out_base_addr(out_base_addr),
        .psum_valid(psum_valid), .psum(psum), .psum_last(psum_last),
        .psum_ready(r_psum_ready), .bias_rd_en(r_bias_rd_en),
        .bias_addr(r_bias_addr), .bias_data(r_bias_data),
        .wr_en(r_wr_en), .wr_addr(r_wr_addr), .wr_data(r_wr_data),
        .neuron_idx(r_neuron_idx), .busy(r_busy),
        .layer_done(r_layer_done), .overflow_flag(r_overflow_flag)
    );

    neuron_accumulator #(.RELU_EN(1'b0)) u_lin (
        .clk(clk), .rst(rst), .layer_start(layer_start),
        .num_neurons(num_neurons), .out_base_addr(out_base_addr),
        .psum_valid(psum_valid), .psum(psum), .psum_last(psum_last),
        .psum_ready(l_psum_ready), .bias_rd_en(l_bias_rd_en),
        .bias_addr(l_bias_addr), .bias_data(l_bias_data),
        .wr_en(l_wr_en), .wr_addr(l_wr_addr), .wr_data(l_wr_data),
        .neuron_idx(l_neuron_idx), .busy(l_busy),
        .layer_done(l_layer_done), .overflow_flag(l_overflow_flag)
    );

    // Bias data is only meaningful the cycle after a read strobe.
    always @(posedge clk) begin
        r_bias_data <= r_bias_rd_en ? bias_mem[r_bias_addr[2:0]] : 16'hDEAD;
        l_bias_data <= l_bias_rd_en ? bias_mem[l_bias_addr[2:0]] : 16'hDEAD;
    end

    always @(posedge clk) begin
        #1;
        if (r_wr_en) begin
            wr_cnt++;
            last_addr = r_wr_addr;
            last_data = r_wr_data;
            last_lin  = l_wr_data;
        end
        if (r_layer_done) done_cnt++;
    end

    task automatic start_layer(input logic [15:0] n, input logic [15:0] base);
        layer_start   = 1'b1;
        num_neurons   = n;
        out_base_addr = base;
        @(negedge clk);
        layer_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input logic last);
        int n = 0;
        psum_valid = 1'b1;
        psum       = v;
        psum_last  = last;
        while (!r_psum_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL send_timeout: psum_ready got %0b want 1", r_psum_ready);
        end
        @(negedge clk);
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    task automatic wait_write(output bit ok);
        int old = wr_cnt;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr_cnt != old) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({r_busy, r_wr_en, r_layer_done, r_psum_ready, r_bias_rd_en,
             r_overflow_flag} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                {r_busy, r_wr_en, r_layer_done, r_psum_ready, r_bias_rd_en,
                 r_overflow_flag});
        end
        checks++;
        if ({r_wr_addr, r_wr_data, r_neuron_idx, r_bias_addr} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                {r_wr_addr, r_wr_data, r_neuron_idx, r_bias_addr});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int d0 = done_cnt;
        bias_mem[0] = 16'h0080;
        bias_mem[1] = 16'hFFFF;
        start_layer(16'd2, 16'h0100);
        send(32'h0001_0000, 1'b0);
        send(32'h0002_0000, 1'b1);
        wait_write(ok);
        checks++;
        if (!ok || last_addr !== 16'h0100 || last_data !== 16'h0380) begin
            errors++;
            $display("FAIL basic_n0: ok=%0b addr=%h data=%h want 0100 0380",
                ok, last_addr, last_data);
        end
        checks++;
        if (last_lin !== 16'h0380) begin
            errors++;
            $display("FAIL basic_n0_lin: got %h want 0380", last_lin);
        end
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL basic_early_done: got %0d want %0d", done_cnt, d0);
        end
        send(32'h0000_5000, 1'b1);
        wait_write(ok);
        checks++;
        if (!ok || last_addr !== 16'h0101 || last_data !== 16'h004F) begin
            errors++;
            $display("FAIL basic_n1: ok=%0b addr=%h data=%h want 0101 004f",
                ok, last_addr, last_data);
        end
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL basic_done: got %0d want %0d", done_cnt, d0 + 1);
        end
        @(negedge clk);
        checks++;
        if (r_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy got %0b want 0", r_busy);
        end
    endtask

    task automatic test_relu;
        bit ok;
        bias_mem[0] = 16'h0000;
        start_layer(16'd1, 16'h0200);
        send(32'hFFFE_0000, 1'b1);
        wait_write(ok);
        checks++;
        if (!ok || last_data !== 16'h0000 || last_addr !== 16'h0200) begin
            errors++;
            $display("FAIL relu_on: ok=%0b data=%h addr=%h want 0000 0200",
                ok, last_data, last_addr);
        end
        checks++;
        if (last_lin !== 16'hFE00) begin
            errors++;
            $display("FAIL relu_off: got %h want fe00", last_lin);
        end
        checks++;
        if (r_overflow_flag !== 1'b0 || l_overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL relu_ovf: got %b%b want 00",
                r_overflow_flag, l_overflow_flag);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        bit ok;
        bias_mem[0] = 16'h0000;
        start_layer(16'd1, 16'h0300);
        send(32'h7FFF_0000, 1'b0);
        send(32'h7FFF_0000, 1'b1);
        checks++;
        if (u_relu.acc !== 32'h7FFF_FFFF || r_overflow_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_acc: acc=%h ovf=%0b want 7fffffff 1",
                u_relu.acc, r_overflow_flag);
        end
        wait_write(ok);
        checks++;
        if (!ok || last_data !== 16'h7FFF || last_lin !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos: ok=%0b relu=%h lin=%h want 7fff",
                ok, last_data, last_lin);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (r_overflow_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: got %0b want 1", r_overflow_flag);
        end
        start_layer(16'd1, 16'h0310);
        checks++;
        if (r_overflow_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got %0b want 0", r_overflow_flag);
        end
        send(32'h8000_0000, 1'b0);
        send(32'h8000_0000, 1'b1);
        wait_write(ok);
        checks++;
        if (!ok || last_data !== 16'h0000 || last_lin !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg: ok=%0b relu=%h lin=%h want 0000 8000",
                ok, last_data, last_lin);
        end
        checks++;
        if (r_overflow_flag !== 1'b1 || l_overflow_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg_ovf: got %b%b want 11",
                r_overflow_flag, l_overflow_flag);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bias_mem[0] = 16'h0010;
        bias_mem[1] = 16'hFFF0;
        start_layer(16'd2, 16'h0020);
        psum_valid = 1'b1;
        psum       = 32'h0001_0000;
        psum_last  = 1'b1;
        checks++;
        if (r_psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_T: got %0b want 1", r_psum_ready);
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (r_psum_ready !== (k == 5)) begin
                errors++;
                $display("FAIL b2b_ready k=%0d: got %0b want %0b",
                    k, r_psum_ready, (k == 5));
            end
            if (k == 1 || k == 6) begin
                checks++;
                if (r_bias_rd_en !== 1'b1 || r_bias_addr !== 16'(k / 6)) begin
                    errors++;
                    $display("FAIL b2b_bias k=%0d: en=%0b addr=%h",
                        k, r_bias_rd_en, r_bias_addr);
                end
            end
            if (k == 4) begin
                checks++;
                if (r_wr_en !== 1'b1 || r_wr_data !== 16'h0110 ||
                    r_wr_addr !== 16'h0020 || r_layer_done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_wr0: en=%0b data=%h addr=%h done=%0b",
                        r_wr_en, r_wr_data, r_wr_addr, r_layer_done);
                end
                psum = 32'h0002_0000;
            end
            if (k == 9) begin
                checks++;
                if (r_wr_en !== 1'b1 || r_wr_data !== 16'h01F0 ||
                    r_wr_addr !== 16'h0021 || r_layer_done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_wr1: en=%0b data=%h addr=%h done=%0b",
                        r_wr_en, r_wr_data, r_wr_addr, r_layer_done);
                end
                psum_valid = 1'b0;
                psum_last  = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (r_layer_done !== 1'b0 || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: done=%0b busy=%0b want 0 0",
                r_layer_done, r_busy);
        end
    endtask

    task automatic test_empty_and_busy;
        bit ok;
        int w0 = wr_cnt;
        layer_start   = 1'b1;
        num_neurons   = 16'd0;
        out_base_addr = 16'h0900;
        @(negedge clk);
        layer_start = 1'b0;
        checks++;
        if (r_layer_done !== 1'b1 || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: done=%0b busy=%0b want 1 0",
                r_layer_done, r_busy);
        end
        @(negedge clk);
        checks++;
        if (r_layer_done !== 1'b0) begin
            errors++;
            $display("FAIL empty_pulse: got %0b want 0", r_layer_done);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL empty_nowr: got %0d want %0d", wr_cnt, w0);
        end
        bias_mem[0] = 16'h0000;
        start_layer(16'd1, 16'h0400);
        start_layer(16'd5, 16'h0500);
        checks++;
        if (r_busy !== 1'b1 || r_neuron_idx !== 16'd0 || r_psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore: busy=%0b idx=%h rdy=%0b",
                r_busy, r_neuron_idx, r_psum_ready);
        end
        send(32'h0000_0100, 1'b1);
        wait_write(ok);
        checks++;
        if (!ok || last_addr !== 16'h0400 || last_data !== 16'h0001 ||
            r_layer_done !== 1'b1) begin
            errors++;
            $display("FAIL busy_result: ok=%0b addr=%h data=%h done=%0b",
                ok, last_addr, last_data, r_layer_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midlayer;
        bit ok;
        int w0;
        bias_mem[0] = 16'h0000;
        start_layer(16'd1, 16'h0600);
        send(32'h0005_0000, 1'b1);
        @(negedge clk);
        w0  = wr_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({r_busy, r_wr_en, r_layer_done, r_psum_ready, r_bias_rd_en,
             r_overflow_flag} !== 6'b0 ||
            {r_wr_addr, r_wr_data, r_neuron_idx} !== 48'h0) begin
            errors++;
            $display("FAIL midrst_out: ctrl=%b addr=%h data=%h idx=%h",
                {r_busy, r_wr_en, r_layer_done, r_psum_ready, r_bias_rd_en,
                 r_overflow_flag}, r_wr_addr, r_wr_data, r_neuron_idx);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL midrst_nowr: got %0d want %0d", wr_cnt, w0);
        end
        bias_mem[0] = 16'h0001;
        start_layer(16'd1, 16'h0700);
        send(32'h0003_0000, 1'b1);
        wait_write(ok);
        checks++;
        if (!ok || last_addr !== 16'h0700 || last_data !== 16'h0301) begin
            errors++;
            $display("FAIL midrst_next: ok=%0b addr=%h data=%h want 0700 0301",
                ok, last_addr, last_data);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bias_mem[i] = 16'h0000;
        rst           = 1'b1;
        layer_start   = 1'b0;
        num_neurons   = 16'd0;
        out_base_addr = 16'd0;
        psum_valid    = 1'b0;
        psum          = 32'd0;
        psum_last     = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_relu;
        test_saturation;
        test_back_to_back;
        test_empty_and_busy;
        test_reset_midlayer;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
